// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// op encodings, FSM states and default datapath width.
package mips_muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } muldiv_state_e;

    function automatic logic op_is_signed(logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned radix-2 engine: shift-add multiply or restoring divide, one bit per step.
// Result is the 2*WIDTH product, or {remainder, quotient} in divide mode.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand_b;
    logic               div_mode;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    // Multiply: upper half accumulates, multiplier bits drain out of the lower half.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
    // Divide: shift the next dividend bit into the partial remainder, then trial-subtract.
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, operand_b};
    assign div_diff = div_sh - {1'b0, operand_b};

    assign last   = (cnt == {CNT_W{1'b1}});
    assign result = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            operand_b <= '0;
            div_mode  <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            acc       <= {{WIDTH{1'b0}}, a};
            operand_b <= b;
            div_mode  <= is_div;
            cnt       <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_mode)
                acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
            else
                acc <= {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences the iterative engine
// with sign pre/post-fixup, and requests stalls for dependent instructions.
import mips_muldiv_pkg::*;

module ex_muldiv #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mf_req,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e state;

    logic             is_div_q;
    logic             neg_q;       // product / quotient sign
    logic             rem_neg_q;   // remainder follows the dividend
    logic             dbz_q;
    logic [WIDTH-1:0] a_raw_q;

    logic             a_neg, b_neg, sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;
    logic             eng_last;
    logic [2*WIDTH-1:0] eng_res;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign sgn    = op_is_signed(op);
    assign a_neg  = sgn && busA[WIDTH-1];
    assign b_neg  = sgn && busB[WIDTH-1];
    assign a_mag  = a_neg ? -busA : busA;
    assign b_mag  = b_neg ? -busB : busB;
    assign accept = (state == S_IDLE) && start && !flush && (op <= OP_DIVU);

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == S_CALC),
        .is_div (op[1]),
        .a      (a_mag),
        .b      (b_mag),
        .last   (eng_last),
        .result (eng_res)
    );

    always_comb begin
        prod_fix = neg_q ? -eng_res : eng_res;
        quo_fix  = neg_q ? -eng_res[WIDTH-1:0] : eng_res[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -eng_res[2*WIDTH-1:WIDTH] : eng_res[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    assign busy      = (state != S_IDLE);
    assign stall_req = busy && (start || mf_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            a_raw_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: hi <= busA;
                            OP_MTLO: lo <= busA;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q  <= op[1];
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                dbz_q     <= (busB == '0);
                                a_raw_q   <= busA;
                                state     <= S_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush)
                        state <= S_IDLE;
                    else if (eng_last)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed boundary cases plus randomized
// mult/div against a plain-arithmetic reference model.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] busA = '0;
    logic [W-1:0] busB = '0;
    logic         mf_req = 1'b0;
    logic         flush = 1'b0;
    logic         busy, stall_req, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .busA(busA), .busB(busB),
        .mf_req(mf_req), .flush(flush), .busy(busy), .stall_req(stall_req),
        .done(done), .hi(hi), .lo(lo)
    );

    // Reference: returns {hi, lo} from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {(a % b), (a / b)};
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; busA = a; busB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, stall_req} !== 3'b000 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset: busy/done/stall=%b hi=%h lo=%h, required 000 0 0", {busy, done, stall_req}, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2};
        logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
                                  32'h8000_0000, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] t_b  [7] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0,
                                  32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
        logic [31:0] t_hi [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h64,
                                  32'h0, 32'hFFFF_FFF9, 32'd1};
        logic [31:0] t_lo [7] = '{32'h1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        int n;
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_idle(n);
            checks++;
            if (n !== 33 || done !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] timing: busy=%0d done=%b, required 33 1", i, n, done);
            end
            checks++;
            if (hi !== t_hi[i] || lo !== t_lo[i]) begin
                errors++;
                $display("FAIL directed[%0d] result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        int n, bad;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp = model(o, a, b);
            issue(o, a, b);
            wait_idle(n);
            checks++;
            if (n !== 33 || done !== 1'b1 || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%0d done=%b hi:lo=%h, required 33 1 %h",
                         i, o, a, b, n, done, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_mt();
        issue(3'd4, 32'h1234, 32'hDEAD);
        checks++;
        if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b done=%b, required 1234 0 0", hi, busy, done);
        end
        issue(3'd5, 32'h5678, 32'hBEEF);
        checks++;
        if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, required 1234 5678 0", hi, lo, busy);
        end
    endtask

    task automatic test_stall();
        int n, bad;
        issue(3'd3, 32'd100, 32'd7);
        mf_req = 1'b1;
        #1;
        n = 0; bad = 0;
        while (busy && n < 100) begin
            if (stall_req !== 1'b1) bad++;
            if (n == 5) begin start = 1'b1; op = 3'd1; busA = 32'd3; busB = 32'd3; end
            if (n == 10) start = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || n !== 33) begin
            errors++;
            $display("FAIL stall_busy: low-stall cycles=%0d busy=%0d, required 0 33", bad, n);
        end
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL stall_done: stall=%b done=%b hi=%h lo=%h, required 0 1 2 e", stall_req, done, hi, lo);
        end
        mf_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_restart: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_flush();
        int seen;
        issue(3'd4, 32'h1234, 32'h0);
        issue(3'd5, 32'h5678, 32'h0);
        // flush mid-CALC
        issue(3'd0, $urandom, $urandom);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: busy=%b, required 0", busy);
        end
        // flush in FIX
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++;
            $display("FAIL flush_keep: done pulses=%0d busy=%b hi=%h lo=%h, required 0 0 1234 5678", seen, busy, hi, lo);
        end
        // synchronous reset mid-CALC
        issue(3'd0, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL rst_mid: done pulses=%0d busy=%b hi=%h lo=%h, required 0 0 0 0", seen, busy, hi, lo);
        end
    endtask

    task automatic test_start_flush();
        issue(3'd4, 32'hAAAA, 32'h0);
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; busA = 32'd3; busB = 32'd4;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_mult: busy=%b, required 0", busy);
        end
        op = 3'd4; busA = 32'h5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (hi !== 32'hAAAA || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_mt: hi=%h lo=%h busy=%b done=%b, required aaaa 0 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'd1, 32'd6, 32'd7);
        wait_idle(n);
        // issue the next op in the done cycle itself
        start = 1'b1; op = 3'd2; busA = 32'hFFFF_FF9C; busB = 32'd7;
        checks++;
        if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: done=%b hi=%h lo=%h, required 1 0 2a", done, hi, lo);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 33 || done !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin
            errors++;
            $display("FAIL b2b_second: busy=%0d done=%b hi=%h lo=%h, required 33 1 fffffffe fffffff2", n, done, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_stall();
        test_flush();
        test_start_flush();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (busA, busB, decoded op).
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Supplies HI/LO for MFHI/MFLO.
- Raises a stall request to the hazard logic while a dependent instruction must wait.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNT_W, 5, iteration counter width; WIDTH = 2**CNT_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  EX instruction is a muldiv op (op valid)
- op  in  3  operation code (see package)
- busA  in  WIDTH  rs operand
- busB  in  WIDTH  rt operand
- mf_req  in  1  EX instruction is MFHI/MFLO
- flush  in  1  kill EX instruction / in-flight operation
- busy  out  1  iteration in progress
- stall_req  out  1  hold PC, IF/ID and ID/EX this cycle
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation; HI/LO are cleared.
- FSM states:
  - IDLE: start && !flush with op MULT/MULTU/DIV/DIVU → latch operand magnitudes (signed ops: two's-complement abs), result signs and divide-by-zero flag; counter=0; go to CALC.
  - CALC: one radix-2 step per cycle (shift-add for multiply; restoring shift-subtract for divide); counter++. After the step with counter=WIDTH-1, go to FIX.
  - FIX: apply sign correction; write hi/lo at the end of this cycle; go to IDLE.
- Timing:
  - busy = (state != IDLE). This gives 33 busy cycles after the accept edge for WIDTH=32.
  - done is registered. It is 1 in the first IDLE cycle after FIX, the same cycle new hi/lo are visible.
- MTHI/MTLO: in IDLE, with start && !flush, write busA to hi/lo at the next edge (1-cycle latency). No busy, no done.
- Multiply results:
  - hi:lo = 64-bit product.
  - MULT is negated when the operand signs differ.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed quotient sign = sign(A) xor sign(B). Remainder takes the sign of A.
- Divide boundaries:
  - Divide by zero (any div op): lo=all ones, hi=busA as issued. Still takes the full 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_req (combinational) = busy && (start || mf_req). It drops in the cycle busy drops, so MFHI/MFLO then read the new values.
- start while busy: ignored by the FSM; stall_req holds the instruction in EX until IDLE.
- flush:
  - In IDLE, flush suppresses start.
  - In CALC/FIX, flush returns to IDLE at the next edge with hi/lo unchanged and no done.
  - flush wins over a simultaneous start.
- Output mapping: hi/lo outputs are the registers themselves. The EX result mux selects them for MFHI/MFLO.

Decomposition:
- Shared package mips_muldiv_pkg:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5
  - FSM state encoding: IDLE, CALC, FIX
  - WIDTH default
- One natural sub-module, muldiv_iter:
  - unsigned iterative engine: accumulator, shift register, counter
  - driven by load/step strobes; returns the raw unsigned 64-bit product or quotient/remainder
- Sign pre-/post-fixup, HI/LO registers, FSM and stall logic stay in ex_muldiv.

Test Plan:
- MULTU busA=0xFFFFFFFF, busB=0xFFFFFFFF → busy for 33 cycles; then done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT busA=0xFFFFFFFD (-3), busB=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV busA=0xFFFFFFF9 (-7), busB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU busA=100, busB=0 → lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100/7 issued, mf_req=1 on the following cycle → stall_req=1 for every busy cycle and 0 in the done cycle, when lo=14, hi=2. A second start while busy → stall_req=1 and no restart.
- Preload via MTHI 0x1234 and MTLO 0x5678 (1 cycle each); then MULT, with flush at CALC cycle 10 → IDLE next cycle, done never pulses, hi=0x1234, lo=0x5678. Repeat with rst at cycle 10 → hi=lo=0.
- start and flush asserted in the same IDLE cycle → no state change, busy stays 0, HI/LO unchanged.
